// File: rtl/traffic_pkg.sv
// Shared encodings for the phase controller: lamp codes per signal head and
// the controller state enumeration.
package traffic_pkg;

  localparam logic [1:0] SIG_GREEN = 2'b00;
  localparam logic [1:0] SIG_YEL   = 2'b01;
  localparam logic [1:0] SIG_RED   = 2'b10;
  localparam logic [1:0] SIG_RA    = 2'b11;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    RED_AMBER = 3'd1,
    GREEN     = 3'd2,
    YELLOW    = 3'd3,
    FLASH     = 3'd4
  } state_e;

endpackage

// File: rtl/traffic_phase_timer.sv
// Per-state tick counter. Saturates at dur-1 so a resting state reports done on
// every qualified tick.
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             clr,
  input  logic             qt,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last = (dur == '0) ? '0 : dur - 1'b1;
  assign done = qt & (cnt == last);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (qt && (cnt != last)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated intersection controller cycling N_PH phases over N_CH heads,
// with per-phase demand skip and a flashing maintenance mode.
//   state     | meaning
//   ALL_RED   | clearance, phase selection, or resting with no demand
//   RED_AMBER | active heads red-amber before green
//   GREEN     | active heads green for green_time[phase_idx] ticks
//   YELLOW    | active heads yellow, always runs to completion
//   FLASH     | all heads alternate yellow/red on each qualified tick
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int N_PH  = 4,
  parameter int CNT_W = 8,
  parameter int T_RA  = 2,
  parameter int T_YEL = 2,
  parameter int T_CLR = 1,
  parameter int PH_W  = $clog2(N_PH)
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic                  Go,
  input  logic                  tick_en,
  input  logic [N_PH*CNT_W-1:0] green_time,
  input  logic [N_PH*N_CH-1:0]  phase_heads,
  input  logic [N_PH-1:0]       skip_en,
  input  logic [N_PH-1:0]       req,
  input  logic                  flash,
  output logic [2*N_CH-1:0]     heads,
  output logic [PH_W-1:0]       phase_idx,
  output logic [2:0]            state_o,
  output logic                  flashing
);

  state_e            state, state_nxt;
  logic [PH_W-1:0]   ph_nxt, sel, cand;
  logic              flash_ph, flash_ph_nxt;
  logic [N_PH-1:0]   dem, green_clr;
  logic              qt, done, clr, found;
  logic [CNT_W-1:0]  dur, green_dur;
  logic [N_CH-1:0]   mask;
  logic [2*N_CH-1:0] heads_nxt;

  assign qt      = Go & tick_en;
  assign clr     = (state_nxt != state);
  assign state_o = state;

  always_comb begin
    green_dur = '0;
    green_clr = '0;
    for (int p = 0; p < N_PH; p++) begin
      if (PH_W'(p) == phase_idx) begin
        green_dur    = green_time[p*CNT_W +: CNT_W];
        green_clr[p] = (state == GREEN);
      end
    end
  end

  always_comb begin
    unique case (state)
      RED_AMBER: dur = CNT_W'(T_RA);
      GREEN:     dur = green_dur;
      YELLOW:    dur = CNT_W'(T_YEL);
      default:   dur = CNT_W'(T_CLR);
    endcase
  end

  traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .Rst_n (Rst_n),
    .clr   (clr),
    .qt    (qt),
    .dur   (dur),
    .done  (done)
  );

  // Cyclic search starting after the last-served phase.
  always_comb begin
    found = 1'b0;
    sel   = phase_idx;
    cand  = '0;
    for (int k = 1; k <= N_PH; k++) begin
      cand = PH_W'((int'(phase_idx) + k) % N_PH);
      if (!found && (!skip_en[cand] || dem[cand])) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ph_nxt       = phase_idx;
    flash_ph_nxt = flash_ph;
    if (qt) begin
      unique case (state)
        ALL_RED: begin
          if (done && flash) begin
            state_nxt    = FLASH;
            flash_ph_nxt = 1'b0;
          end else if (done && found) begin
            state_nxt = RED_AMBER;
            ph_nxt    = sel;
          end
        end
        RED_AMBER: begin
          if (flash)     state_nxt = ALL_RED;
          else if (done) state_nxt = GREEN;
        end
        GREEN: begin
          if (flash || done) state_nxt = YELLOW;
        end
        YELLOW: begin
          if (done) state_nxt = ALL_RED;
        end
        FLASH: begin
          if (!flash) begin
            state_nxt = ALL_RED;
            ph_nxt    = PH_W'(N_PH - 1);
          end else begin
            flash_ph_nxt = ~flash_ph;
          end
        end
        default: state_nxt = ALL_RED;
      endcase
    end
  end

  // Lamp decode from next-state values so heads switch on the same edge as state.
  always_comb begin
    mask = '0;
    for (int p = 0; p < N_PH; p++) begin
      if (PH_W'(p) == ph_nxt) mask = phase_heads[p*N_CH +: N_CH];
    end
    heads_nxt = {N_CH{SIG_RED}};
    for (int h = 0; h < N_CH; h++) begin
      unique case (state_nxt)
        FLASH:     heads_nxt[2*h +: 2] = flash_ph_nxt ? SIG_RED : SIG_YEL;
        RED_AMBER: if (mask[h]) heads_nxt[2*h +: 2] = SIG_RA;
        GREEN:     if (mask[h]) heads_nxt[2*h +: 2] = SIG_GREEN;
        YELLOW:    if (mask[h]) heads_nxt[2*h +: 2] = SIG_YEL;
        default:   heads_nxt[2*h +: 2] = SIG_RED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ALL_RED;
      phase_idx <= PH_W'(N_PH - 1);
      flash_ph  <= 1'b0;
      heads     <= {N_CH{SIG_RED}};
      flashing  <= 1'b0;
      dem       <= '0;
    end else begin
      state     <= state_nxt;
      phase_idx <= ph_nxt;
      flash_ph  <= flash_ph_nxt;
      heads     <= heads_nxt;
      flashing  <= (state_nxt == FLASH);
      dem       <= (dem | req) & ~green_clr;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with hand-computed lamp patterns.
module tb_traffic_phase_ctrl;

  localparam int N_CH = 4, N_PH = 4, CNT_W = 8, PH_W = 2;

  localparam logic [7:0] AR   = 8'hAA;
  localparam logic [7:0] FL_Y = 8'h55;
  localparam logic [7:0] P0_RA = 8'hAF, P0_G = 8'hA0, P0_Y = 8'hA5;
  localparam logic [7:0] P1_RA = 8'hBA, P1_G = 8'h8A, P1_Y = 8'h9A;
  localparam logic [7:0] P2_RA = 8'hEA, P2_G = 8'h2A, P2_Y = 8'h6A;
  localparam logic [7:0] P3_RA = 8'hAB, P3_G = 8'hA8, P3_Y = 8'hA9;

  logic                  clk, Rst_n, Go, tick_en, flash, flashing;
  logic [N_PH*CNT_W-1:0] green_time;
  logic [N_PH*N_CH-1:0]  phase_heads;
  logic [N_PH-1:0]       skip_en, req;
  logic [2*N_CH-1:0]     heads;
  logic [PH_W-1:0]       phase_idx;
  logic [2:0]            state_o;

  int tests = 0;
  int failed = 0;

  traffic_phase_ctrl #(.N_CH(N_CH), .N_PH(N_PH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .Rst_n       (Rst_n),
    .Go          (Go),
    .tick_en     (tick_en),
    .green_time  (green_time),
    .phase_heads (phase_heads),
    .skip_en     (skip_en),
    .req         (req),
    .flash       (flash),
    .heads       (heads),
    .phase_idx   (phase_idx),
    .state_o     (state_o),
    .flashing    (flashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One served phase: 2 red-amber, gl green, 2 yellow, 1 all-red.
  task automatic phase_seq(input string tag, input logic [7:0] ra, input logic [7:0] g,
                           input logic [7:0] y, input int gl, input int ph,
                           input logic [3:0] pulse);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("%s_ra%0d", tag, i), 32'(heads), 32'(ra));
    end
    chk($sformatf("%s_idx", tag), 32'(phase_idx), 32'(ph));
    for (int i = 0; i < gl; i++) begin
      cyc();
      if (i == 1) req = '0;
      chk($sformatf("%s_g%0d", tag, i), 32'(heads), 32'(g));
      if (i == 0) begin
        chk($sformatf("%s_st_g", tag), 32'(state_o), 32'd2);
        req = pulse;
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("%s_y%0d", tag, i), 32'(heads), 32'(y));
    end
    cyc();
    chk($sformatf("%s_clr", tag), 32'(heads), 32'(AR));
  endtask

  initial begin
    Rst_n = 1'b1; Go = 1'b1; tick_en = 1'b1; flash = 1'b0;
    green_time = 32'h03030303; phase_heads = 16'h1843;
    skip_en = 4'b0000; req = 4'b0000;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_heads", 32'(heads), 32'(AR));
    chk("rst_flashing", 32'(flashing), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_idx", 32'(phase_idx), 32'd3);
    repeat (2) @(posedge clk);
    #1 Rst_n = 1'b1;
    chk("rel_ar", 32'(heads), 32'(AR));

    // Full 4-phase cycle.
    phase_seq("c_p0", P0_RA, P0_G, P0_Y, 3, 0, 4'b0000);
    phase_seq("c_p1", P1_RA, P1_G, P1_Y, 3, 1, 4'b0000);
    phase_seq("c_p2", P2_RA, P2_G, P2_Y, 3, 2, 4'b0000);
    phase_seq("c_p3", P3_RA, P3_G, P3_Y, 3, 3, 4'b0000);

    // Demand skip: p2 requested once during p0 green, p1 never requested.
    skip_en = 4'b0110;
    phase_seq("s_p0", P0_RA, P0_G, P0_Y, 3, 0, 4'b0100);
    phase_seq("s_p2", P2_RA, P2_G, P2_Y, 3, 2, 4'b0000);
    chk("s_dem2", 32'(dut.dem[2]), 32'd0);
    phase_seq("s_p3", P3_RA, P3_G, P3_Y, 3, 3, 4'b0000);
    phase_seq("s_p0b", P0_RA, P0_G, P0_Y, 3, 0, 4'b0000);
    skip_en = 4'b1110;

    // Freeze with Go=0 at green timer=1.
    cyc(); chk("go_ra0", 32'(heads), 32'(P0_RA));
    cyc(); chk("go_ra1", 32'(heads), 32'(P0_RA));
    cyc(); chk("go_g0", 32'(heads), 32'(P0_G));
    cyc(); chk("go_g1", 32'(heads), 32'(P0_G));
    Go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("go_hold%0d", i), 32'(heads), 32'(P0_G));
    end
    Go = 1'b1;
    cyc(); chk("go_g2", 32'(heads), 32'(P0_G));
    cyc(); chk("go_y0", 32'(heads), 32'(P0_Y));
    cyc(); chk("go_y1", 32'(heads), 32'(P0_Y));
    cyc(); chk("go_clr", 32'(heads), 32'(AR));

    // Flash request during green.
    cyc(); chk("fl_ra0", 32'(heads), 32'(P0_RA));
    cyc(); chk("fl_ra1", 32'(heads), 32'(P0_RA));
    cyc(); chk("fl_g0", 32'(heads), 32'(P0_G));
    flash = 1'b1;
    cyc(); chk("fl_y0", 32'(heads), 32'(P0_Y));
    cyc(); chk("fl_y1", 32'(heads), 32'(P0_Y));
    cyc(); chk("fl_clr", 32'(heads), 32'(AR));
    cyc(); chk("fl_f0", 32'(heads), 32'(FL_Y));
    chk("fl_flag", 32'(flashing), 32'd1);
    chk("fl_state", 32'(state_o), 32'd4);
    cyc(); chk("fl_f1", 32'(heads), 32'(AR));
    cyc(); chk("fl_f2", 32'(heads), 32'(FL_Y));
    cyc(); chk("fl_f3", 32'(heads), 32'(AR));
    skip_en = 4'b0000;
    flash = 1'b0;
    cyc(); chk("fl_exit_ar", 32'(heads), 32'(AR));
    chk("fl_exit_flag", 32'(flashing), 32'd0);
    chk("fl_exit_idx", 32'(phase_idx), 32'd3);
    chk("fl_exit_state", 32'(state_o), 32'd0);

    // Phase 0 restarts; async reset during its yellow.
    cyc(); chk("r_ra0", 32'(heads), 32'(P0_RA));
    chk("r_idx", 32'(phase_idx), 32'd0);
    cyc(); chk("r_ra1", 32'(heads), 32'(P0_RA));
    for (int i = 0; i < 3; i++) begin
      cyc(); chk($sformatf("r_g%0d", i), 32'(heads), 32'(P0_G));
    end
    cyc(); chk("r_y0", 32'(heads), 32'(P0_Y));
    #3 Rst_n = 1'b0;
    #1;
    chk("r_async_heads", 32'(heads), 32'(AR));
    chk("r_async_state", 32'(state_o), 32'd0);
    chk("r_async_idx", 32'(phase_idx), 32'd3);
    repeat (2) @(posedge clk);
    #1 Rst_n = 1'b1;
    chk("r_rel_ar", 32'(heads), 32'(AR));
    cyc(); chk("r_rel_ra", 32'(heads), 32'(P0_RA));
    chk("r_rel_idx", 32'(phase_idx), 32'd0);

    // All phases skipped with no demand: rest, then serve p3 on request.
    skip_en = 4'b1111;
    cyc(); chk("z_ra1", 32'(heads), 32'(P0_RA));
    for (int i = 0; i < 3; i++) begin
      cyc(); chk($sformatf("z_g%0d", i), 32'(heads), 32'(P0_G));
    end
    cyc(); chk("z_y0", 32'(heads), 32'(P0_Y));
    cyc(); chk("z_y1", 32'(heads), 32'(P0_Y));
    for (int i = 0; i < 6; i++) begin
      cyc(); chk($sformatf("z_rest%0d", i), 32'(heads), 32'(AR));
    end
    chk("z_rest_state", 32'(state_o), 32'd0);
    green_time[31:24] = 8'd0;
    req = 4'b1000;
    cyc(); chk("z_req_ar", 32'(heads), 32'(AR));
    req = 4'b0000;
    cyc(); chk("z_p3_ra0", 32'(heads), 32'(P3_RA));
    chk("z_p3_idx", 32'(phase_idx), 32'd3);
    cyc(); chk("z_p3_ra1", 32'(heads), 32'(P3_RA));
    cyc(); chk("z_p3_g0", 32'(heads), 32'(P3_G));
    cyc(); chk("z_p3_y0", 32'(heads), 32'(P3_Y));
    cyc(); chk("z_p3_y1", 32'(heads), 32'(P3_Y));
    for (int i = 0; i < 3; i++) begin
      cyc(); chk($sformatf("z_after%0d", i), 32'(heads), 32'(AR));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
